// File: rtl/int_mult_pipe_if.sv
// Operand/result handshake bundle for int_mult_pipe.
// master drives operands and out_ready; slave is the multiplier.
interface int_mult_pipe_if #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_a;
  logic [DATA_W-1:0]     in_b;
  logic                  in_signed;
  logic [TAG_W-1:0]      in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*DATA_W-1:0]   out_c;
  logic [TAG_W-1:0]      out_tag;

  modport master (
    output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    input  in_ready, out_valid, out_c, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    output in_ready, out_valid, out_c, out_tag
  );
endinterface

// File: rtl/int_mult_pipe.sv
// Three-stage chunked integer multiplier: partial products, 3:2 CSA tree, final add.
// Signed mode folds the two's-complement correction terms into the tree as extra operands.
module int_mult_pipe #(
  parameter int DATA_W  = 64,
  parameter int CHUNK_W = 16,
  parameter int TAG_W   = 8
) (
  input  logic            clk,
  input  logic            reset,
  int_mult_pipe_if.slave  bus
);
  localparam int NCH    = (DATA_W + CHUNK_W - 1) / CHUNK_W;
  localparam int EW     = NCH * CHUNK_W;
  localparam int PW     = 2 * DATA_W;
  localparam int XW     = 2 * EW;
  localparam int NOPS   = NCH * NCH + 2;
  localparam int STAGES = 3;

  function automatic int csa_levels(input int n);
    int l;
    l = 0;
    while (n > 2) begin
      n = n - n / 3;
      l++;
    end
    return l;
  endfunction

  localparam int LV = csa_levels(NOPS);

  logic                   en;
  logic [STAGES:1]        vld_pipe;
  logic [TAG_W-1:0]       tag1, tag2;
  logic [EW-1:0]          a_ext, b_ext;
  logic [NOPS-1:0][PW-1:0] ops, ops_q, lvl, lvl_nx;
  logic [PW-1:0]          sum_q, carry_q;
  int                     n_ops;

  assign en            = !vld_pipe[STAGES] || bus.out_ready;
  assign bus.in_ready  = en && !reset;
  assign bus.out_valid = vld_pipe[STAGES];

  assign a_ext = EW'(bus.in_a);
  assign b_ext = EW'(bus.in_b);

  for (genvar i = 0; i < NCH; i++) begin : g_row
    for (genvar j = 0; j < NCH; j++) begin : g_col
      assign ops[i*NCH+j] = PW'((XW'(a_ext[i*CHUNK_W +: CHUNK_W]) *
                                 XW'(b_ext[j*CHUNK_W +: CHUNK_W])) << ((i + j) * CHUNK_W));
    end
  end

  // sext(a)*sext(b) = a*b - a_msb*(b<<DATA_W) - b_msb*(a<<DATA_W)  (mod 2^PW)
  assign ops[NOPS-2] = (bus.in_signed && bus.in_a[DATA_W-1]) ?
                       PW'(0) - {bus.in_b, DATA_W'(0)} : '0;
  assign ops[NOPS-1] = (bus.in_signed && bus.in_b[DATA_W-1]) ?
                       PW'(0) - {bus.in_a, DATA_W'(0)} : '0;

  // Wallace-style levels: each group of three becomes sum/carry, leftovers pass through.
  always_comb begin
    lvl    = ops_q;
    lvl_nx = '0;
    n_ops  = NOPS;
    for (int l = 0; l < LV; l++) begin
      lvl_nx = '0;
      for (int g = 0; g < NOPS / 3; g++) begin
        if (g < n_ops / 3) begin
          lvl_nx[2*g]   = lvl[3*g] ^ lvl[3*g+1] ^ lvl[3*g+2];
          lvl_nx[2*g+1] = ((lvl[3*g] & lvl[3*g+1]) | (lvl[3*g] & lvl[3*g+2]) |
                           (lvl[3*g+1] & lvl[3*g+2])) << 1;
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (r < n_ops % 3)
          lvl_nx[2*(n_ops/3)+r] = lvl[3*(n_ops/3)+r];
      end
      n_ops = n_ops - n_ops / 3;
      lvl   = lvl_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe    <= '0;
      ops_q       <= '0;
      tag1        <= '0;
      sum_q       <= '0;
      carry_q     <= '0;
      tag2        <= '0;
      bus.out_c   <= '0;
      bus.out_tag <= '0;
    end else if (en) begin
      vld_pipe    <= {vld_pipe[STAGES-1:1], bus.in_valid};
      ops_q       <= ops;
      tag1        <= bus.in_tag;
      sum_q       <= lvl[0];
      carry_q     <= lvl[1];
      tag2        <= tag1;
      bus.out_c   <= carry_q + sum_q;
      bus.out_tag <= tag2;
    end
  end
endmodule

// File: tb/tb_int_mult_pipe.sv
// Directed and streaming checks of int_mult_pipe at DATA_W=64 and DATA_W=40.
module tb_int_mult_pipe;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int_mult_pipe_if #(.DATA_W(64), .TAG_W(8)) m64 ();
  int_mult_pipe_if #(.DATA_W(40), .TAG_W(8)) m40 ();

  int_mult_pipe #(.DATA_W(64), .CHUNK_W(16), .TAG_W(8)) u64 (.clk(clk), .reset(reset), .bus(m64));
  int_mult_pipe #(.DATA_W(40), .CHUNK_W(16), .TAG_W(8)) u40 (.clk(clk), .reset(reset), .bus(m40));

  typedef struct {
    logic [127:0] c;
    logic [7:0]   tag;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_pop = 0;
  int   n_stall = 0;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  function automatic logic [127:0] ref64(input logic [63:0] a, input logic [63:0] b, input logic s);
    logic [127:0] ae, be;
    ae = s ? {{64{a[63]}}, a} : {64'b0, a};
    be = s ? {{64{b[63]}}, b} : {64'b0, b};
    return ae * be;
  endfunction

  // Scoreboard for the 64-bit instance: pop on output handshake, push on input handshake.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
    end else begin
      if (m64.out_valid && m64.out_ready) begin
        if (q.size() == 0) begin
          chk("sb_extra", 128'(m64.out_tag), 128'hx);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_c", m64.out_c, e.c);
          chk("sb_tag", 128'(m64.out_tag), 128'(e.tag));
          n_pop++;
        end
      end
      if (m64.in_valid && m64.in_ready)
        q.push_back('{c: ref64(m64.in_a, m64.in_b, m64.in_signed), tag: m64.in_tag});
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the result has been checked.
  task automatic run64(input string name, input logic [63:0] a, input logic [63:0] b,
                       input logic s, input logic [7:0] tg, input logic [127:0] e);
    m64.in_a = a; m64.in_b = b; m64.in_signed = s; m64.in_tag = tg; m64.in_valid = 1'b1;
    @(negedge clk) chk({name, "_rdy"}, 128'(m64.in_ready), 128'd1);
    @(posedge clk) #1 m64.in_valid = 1'b0;
    @(negedge clk) chk({name, "_v1"}, 128'(m64.out_valid), 128'd0);
    @(negedge clk) chk({name, "_v2"}, 128'(m64.out_valid), 128'd0);
    @(negedge clk);
    chk({name, "_v3"}, 128'(m64.out_valid), 128'd1);
    chk({name, "_c"}, m64.out_c, e);
    chk({name, "_tag"}, 128'(m64.out_tag), 128'(tg));
    @(posedge clk) #1;
  endtask

  task automatic run40(input string name, input logic [39:0] a, input logic [39:0] b,
                       input logic s, input logic [7:0] tg, input logic [79:0] e);
    m40.in_a = a; m40.in_b = b; m40.in_signed = s; m40.in_tag = tg; m40.in_valid = 1'b1;
    @(negedge clk) chk({name, "_rdy"}, 128'(m40.in_ready), 128'd1);
    @(posedge clk) #1 m40.in_valid = 1'b0;
    @(negedge clk) chk({name, "_v1"}, 128'(m40.out_valid), 128'd0);
    @(negedge clk) chk({name, "_v2"}, 128'(m40.out_valid), 128'd0);
    @(negedge clk);
    chk({name, "_v3"}, 128'(m40.out_valid), 128'd1);
    chk({name, "_c"}, 128'(m40.out_c), 128'(e));
    chk({name, "_tag"}, 128'(m40.out_tag), 128'(tg));
    @(posedge clk) #1;
  endtask

  // Present one operation and hold it until the handshake completes.
  task automatic send64(input logic [63:0] a, input logic [63:0] b, input logic s, input logic [7:0] tg);
    logic acc;
    int   t;
    m64.in_a = a; m64.in_b = b; m64.in_signed = s; m64.in_tag = tg; m64.in_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk) acc = m64.in_ready;
      @(posedge clk) #1;
      t++;
      if (!acc) n_stall++;
    end while (!acc && t < 50);
    if (!acc) chk("send_timeout", 128'd0, 128'd1);
    m64.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    #1 chk("drain_empty", 128'(q.size()), 128'd0);
  endtask

  task automatic stream(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      logic [63:0] a, b;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i % 17 == 3) a = 64'hFFFF_FFFF_FFFF_FFFF;
      if (i % 13 == 5) b = 64'h8000_0000_0000_0000;
      send64(a, b, 1'($urandom_range(0, 1)), 8'(base + i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] hc;
    logic [7:0]   ht;
    reset = 1'b1;
    m64.in_valid = 0; m64.in_a = '0; m64.in_b = '0; m64.in_signed = 0; m64.in_tag = '0; m64.out_ready = 1;
    m40.in_valid = 0; m40.in_a = '0; m40.in_b = '0; m40.in_signed = 0; m40.in_tag = '0; m40.out_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 128'(m64.out_valid), 128'd0);
    chk("rst_out_c", m64.out_c, 128'd0);
    chk("rst_out_tag", 128'(m64.out_tag), 128'd0);
    chk("rst_in_ready", 128'(m64.in_ready), 128'd0);
    chk("rst_out_valid40", 128'(m40.out_valid), 128'd0);
    @(posedge clk) #1 reset = 1'b0;
    @(negedge clk) chk("post_rst_in_ready", 128'(m64.in_ready), 128'd1);
    @(posedge clk) #1;

    run64("umax", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 8'h5A,
          128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    run64("s_m1x2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 8'h11,
          128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE);
    run64("s_min2", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 8'h22,
          128'h4000_0000_0000_0000_0000_0000_0000_0000);
    run64("u_small", 64'd3, 64'd5, 1'b0, 8'h01, 128'd15);
    run64("s_m3x5", 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1, 8'h02,
          128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1);
    run64("u_m1x2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 8'h03,
          128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE);
    run64("s_minxm1", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 8'h04,
          128'h0000_0000_0000_0000_8000_0000_0000_0000);
    run40("u40_max", 40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 1'b0, 8'hA1, 80'hFFFF_FFFF_FE00_0000_0001);
    run40("s40_m1", 40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 1'b1, 8'hA2, 80'd1);

    n_pop = 0; n_stall = 0;
    stream(200, 0);
    drain();
    chk("stream_count", 128'(n_pop), 128'd200);
    chk("stream_stalls", 128'(n_stall), 128'd0);

    n_pop = 0;
    fork
      stream(40, 100);
      begin
        repeat (10) @(posedge clk);
        #1 m64.out_ready = 1'b0;
        @(negedge clk);
        chk("bp_in_ready", 128'(m64.in_ready), 128'd0);
        chk("bp_out_valid", 128'(m64.out_valid), 128'd1);
        hc = m64.out_c; ht = m64.out_tag;
        repeat (4) begin
          @(negedge clk);
          chk("bp_hold_c", m64.out_c, hc);
          chk("bp_hold_tag", 128'(m64.out_tag), 128'(ht));
          chk("bp_in_ready_low", 128'(m64.in_ready), 128'd0);
        end
        @(posedge clk) #1 m64.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 128'(n_pop), 128'd40);

    m64.out_ready = 1'b0;
    send64(64'd7, 64'd9, 1'b0, 8'hE1);
    send64(64'd11, 64'd13, 1'b0, 8'hE2);
    send64(64'd17, 64'd19, 1'b0, 8'hE3);
    reset = 1'b1;
    @(negedge clk) chk("rst_mid_in_ready", 128'(m64.in_ready), 128'd0);
    @(posedge clk) #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", 128'(m64.out_valid), 128'd0);
    chk("rst_mid_out_c", m64.out_c, 128'd0);
    chk("rst_mid_in_ready1", 128'(m64.in_ready), 128'd1);
    @(posedge clk) #1 m64.out_ready = 1'b1;
    run64("post_rst", 64'd6, 64'd7, 1'b0, 8'h77, 128'd42);
    repeat (5) @(posedge clk);
    #1 chk("sb_left", 128'(q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
